// File: rtl/exibidor_sequencia_pkg.sv
// Shared definitions for the sequence display: state codes and default timing.
package exibidor_sequencia_pkg;

  localparam int unsigned T_ON_PADRAO  = 1000;
  localparam int unsigned T_OFF_PADRAO = 500;
  localparam int unsigned ESTADO_W     = 4;

  // 4-bit codes are shared with the control unit and the debug display
  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO       = 4'h0,
    CARREGA      = 4'h1,
    ACENDE       = 4'h2,
    APAGA        = 4'h3,
    PROXIMO      = 4'h4,
    FIM_EXIBICAO = 4'hF
  } estado_t;

endpackage

// File: rtl/exibidor_sequencia_contador.sv
// contador_tempo: up-counter with synchronous clear/enable; fim flags the last cycle before limite.
module contador_tempo #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         zera_i,
  input  logic         conta_i,
  input  logic [W-1:0] limite_i,
  output logic         fim_c_o
);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (zera_i) begin
      contagem_d = '0;
    end else if (conta_i) begin
      contagem_d = contagem_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  // High on the limite-th cycle of a count started from zero
  assign fim_c_o = (contagem_q == (limite_i - W'(1)));

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays sequence memory entries 0..rodada on the LEDs, each lit T_ON cycles then dark T_OFF cycles.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned T_ON   = T_ON_PADRAO,
  parameter int unsigned T_OFF  = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int unsigned T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned TIMER_W = $clog2(T_MAX + 1);

  estado_t             estado_q, estado_d;
  logic [ADDR_W-1:0]   endereco_q, endereco_d;
  logic [ADDR_W-1:0]   rodada_q, rodada_d;
  logic [DATA_W-1:0]   leds_q, leds_d;

  logic                conta_c;
  logic                zera_c;
  logic                fim_c;
  logic [TIMER_W-1:0]  limite_c;

  contador_tempo #(
    .W (TIMER_W)
  ) u_contador_tempo (
    .clk_i    (clock),
    .rst_n_i  (reset),
    .zera_i   (zera_c),
    .conta_i  (conta_c),
    .limite_i (limite_c),
    .fim_c_o  (fim_c)
  );

  // Timer runs only while lit or dark and restarts on every phase change
  always_comb begin
    conta_c  = (estado_q == ACENDE) || (estado_q == APAGA);
    zera_c   = !conta_c || fim_c;
    limite_c = (estado_q == APAGA) ? TIMER_W'(T_OFF) : TIMER_W'(T_ON);
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    leds_d     = leds_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          estado_d   = CARREGA;
          rodada_d   = rodada;
          endereco_d = '0;
        end
      end
      CARREGA: begin
        leds_d   = dado;
        estado_d = ACENDE;
      end
      ACENDE: begin
        if (fim_c) estado_d = APAGA;
      end
      APAGA: begin
        if (fim_c) estado_d = (endereco_q != rodada_q) ? PROXIMO : FIM_EXIBICAO;
      end
      PROXIMO: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = CARREGA;
      end
      FIM_EXIBICAO: estado_d = OCIOSO;
      default:      estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      rodada_q   <= '0;
      leds_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      leds_q     <= leds_d;
    end
  end

  // Moore decode from state and registers only
  assign endereco  = endereco_q;
  assign leds      = (estado_q == ACENDE) ? leds_q : '0;
  assign exibindo  = (estado_q != OCIOSO) && (estado_q != FIM_EXIBICAO);
  assign pronto    = (estado_q == FIM_EXIBICAO);
  assign db_estado = 4'(estado_q);

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with T_ON=4, T_OFF=2 and a 16-entry behavioural memory.
module tb_exibidor_sequencia;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned T_ON   = 4;
  localparam int unsigned T_OFF  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [ADDR_W-1:0] rodada;
  logic [DATA_W-1:0] dado;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              exibindo;
  logic              pronto;
  logic [3:0]        db_estado;

  logic [DATA_W-1:0] mem [16];
  int                vecs = 0;
  int                errs = 0;

  exibidor_sequencia #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .rodada    (rodada),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  assign dado = mem[endereco];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered while sampling carrega; leaves one edge after the last dark cycle
  task automatic show_entry(input logic [3:0] exp_led, input logic [3:0] exp_addr, input bit poke);
    check("carrega_state", 32'(db_estado), 32'h1);
    check("carrega_addr", 32'(endereco), 32'(exp_addr));
    check("carrega_leds", 32'(leds), 32'h0);
    for (int i = 0; i < int'(T_ON); i++) begin
      tick();
      if (poke && i == 0) begin
        iniciar = 1'b1;
        rodada  = 4'd0;
      end
      check("lit_state", 32'(db_estado), 32'h2);
      check("lit_leds", 32'(leds), 32'(exp_led));
      check("lit_exib", 32'(exibindo), 32'h1);
      check("lit_pronto", 32'(pronto), 32'h0);
    end
    if (poke) iniciar = 1'b0;
    for (int i = 0; i < int'(T_OFF); i++) begin
      tick();
      check("dark_state", 32'(db_estado), 32'h3);
      check("dark_leds", 32'(leds), 32'h0);
      check("dark_exib", 32'(exibindo), 32'h1);
    end
    tick();
  endtask

  task automatic expect_proximo(input logic [3:0] exp_addr);
    check("prox_state", 32'(db_estado), 32'h4);
    check("prox_pronto", 32'(pronto), 32'h0);
    check("prox_addr", 32'(endereco), 32'(exp_addr));
    tick();
  endtask

  task automatic expect_fim(input logic [3:0] exp_addr);
    check("fim_state", 32'(db_estado), 32'hF);
    check("fim_pronto", 32'(pronto), 32'h1);
    check("fim_exib", 32'(exibindo), 32'h0);
    check("fim_addr", 32'(endereco), 32'(exp_addr));
    tick();
    check("post_state", 32'(db_estado), 32'h0);
    check("post_pronto", 32'(pronto), 32'h0);
  endtask

  task automatic start(input logic [3:0] r);
    rodada  = r;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  initial begin
    logic [3:0] trace [18];
    trace = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h1,
              4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h3, 4'hF, 4'h0, 4'h1};
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;
    for (int i = 4; i < 16; i++) mem[i] = 4'(i);
    reset   = 1'b0;
    iniciar = 1'b0;
    rodada  = '0;
    tick();
    tick();
    check("rst_state", 32'(db_estado), 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_addr", 32'(endereco), 32'h0);
    check("rst_pronto", 32'(pronto), 32'h0);
    check("rst_exib", 32'(exibindo), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_state", 32'(db_estado), 32'h0);

    // rodada=0: single entry
    start(4'd0);
    show_entry(4'b0001, 4'd0, 1'b0);
    expect_fim(4'd0);

    // rodada=3: four entries
    start(4'd3);
    for (int i = 0; i < 4; i++) begin
      show_entry(mem[i], 4'(i), 1'b0);
      if (i < 3) expect_proximo(4'(i));
    end
    expect_fim(4'd3);

    // rodada=2 with rodada/iniciar disturbed during entry 1
    start(4'd2);
    show_entry(mem[0], 4'd0, 1'b0);
    expect_proximo(4'd0);
    show_entry(mem[1], 4'd1, 1'b1);
    expect_proximo(4'd1);
    show_entry(mem[2], 4'd2, 1'b0);
    expect_fim(4'd2);
    tick();
    check("no2nd_state", 32'(db_estado), 32'h0);
    check("no2nd_pronto", 32'(pronto), 32'h0);

    // reset in the middle of entry 2
    start(4'd3);
    show_entry(mem[0], 4'd0, 1'b0);
    expect_proximo(4'd0);
    show_entry(mem[1], 4'd1, 1'b0);
    expect_proximo(4'd1);
    tick();
    check("mid_leds", 32'(leds), 32'b0100);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_state", 32'(db_estado), 32'h0);
    check("mrst_leds", 32'(leds), 32'h0);
    check("mrst_addr", 32'(endereco), 32'h0);
    check("mrst_pronto", 32'(pronto), 32'h0);
    tick();
    check("mrst_idle", 32'(db_estado), 32'h0);
    start(4'd0);
    show_entry(mem[0], 4'd0, 1'b0);
    expect_fim(4'd0);

    // rodada=15: all sixteen entries, no wrap
    start(4'd15);
    for (int i = 0; i < 16; i++) begin
      show_entry(mem[i], 4'(i), 1'b0);
      if (i < 15) expect_proximo(4'(i));
    end
    expect_fim(4'd15);

    // iniciar held high: automatic restart after pronto
    rodada  = 4'd1;
    iniciar = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      check("held_state", 32'(db_estado), 32'(trace[i]));
      check("held_pronto", 32'(pronto), (trace[i] == 4'hF) ? 32'h1 : 32'h0);
    end
    iniciar = 1'b0;
    reset   = 1'b0;
    tick();
    check("end_state", 32'(db_estado), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
